systolic_array_ctrl: RTL

//  Job sequencer for the 5x5 weight-stationary systolic array (row weights 1..5).
//  - Accepts 5-byte input vectors over a valid/ready handshake.
//  - Applies the per-row input skew and pulses the array clear at job start.
//  - Counts the job length, deskews the 5 column results and tags each aligned result with out_valid.
//  - Sits between the host/tile I/O mux and the array instance.

---
 rtl/systolic_array_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/systolic_array_ctrl.sv
// Job sequencer for the 5x5 weight-stationary systolic array: input skew, array clear,
// job-length counting, result deskew and out_valid tagging.
module systolic_array_ctrl #(
    parameter int LEN_W  = 4,
    parameter int PE_LAT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_cfg_len,
    output logic             o_busy,
    output logic             o_done,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [39:0]      i_in_data,
    output logic [39:0]      o_arr_data,
    output logic             o_arr_clear,
    input  logic [79:0]      i_arr_result,
    output logic             o_out_valid,
    output logic [79:0]      o_out_data,
    output logic [LEN_W-1:0] o_out_count
);

    localparam int LAT   = 2 + 9 * PE_LAT;
    localparam int DRN_W = $clog2(LAT + 1);
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [LEN_W-1:0] r_job_len;
    logic [LEN_W-1:0] r_acc_cnt;
    logic [LEN_W-1:0] r_out_count;
    logic [DRN_W-1:0] r_drain_cnt;
    logic [39:0]      r_arr_in;
    logic [LAT-1:0]   r_tag;
    logic [79:0]      r_out_data;
    logic [39:0]      w_lanes;
    logic [79:0]      w_aligned;
    logic             w_feed_rdy;
    logic             w_hs;
    logic             w_last_hs;
    logic             w_drain_end;
    logic             w_busy;
    logic             w_done;
    logic             w_clear;
    logic             w_arr_en;

    assign w_feed_rdy  = (r_state == S_FEED) && (r_acc_cnt < r_job_len);
    assign o_in_ready  = w_feed_rdy && !i_rst;
    assign w_hs        = i_in_valid && o_in_ready;
    assign w_last_hs   = w_hs && ((r_acc_cnt + ONE) == r_job_len);
    assign w_drain_end = (r_drain_cnt == DRN_W'(LAT - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Reset forces every status output low but holds the array in clear.
    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_clear      = 1'b0;
        w_arr_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_busy       = 1'b1;
                w_clear      = 1'b1;
                w_next_state = (r_job_len == '0) ? S_DONE : S_FEED;
            end
            S_FEED: begin
                w_busy   = 1'b1;
                w_arr_en = 1'b1;
                if (w_last_hs) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_busy   = 1'b1;
                w_arr_en = 1'b1;
                if (w_drain_end) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_busy       = 1'b1;
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        if (i_rst) begin
            w_busy   = 1'b0;
            w_done   = 1'b0;
            w_clear  = 1'b1;
            w_arr_en = 1'b0;
        end
    end

    assign o_busy      = w_busy;
    assign o_done      = w_done;
    assign o_arr_clear = w_clear;
    assign o_arr_data  = w_arr_en ? w_lanes : '0;

    // Drain counter restarts every FEED cycle so it measures from the last handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_job_len   <= '0;
            r_acc_cnt   <= '0;
            r_out_count <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (w_hs) begin
                r_acc_cnt <= r_acc_cnt + ONE;
            end
            if (r_state == S_FEED) begin
                r_drain_cnt <= '0;
            end else if (r_state == S_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end
            if (r_tag[LAT-2] && (r_out_count < r_job_len)) begin
                r_out_count <= r_out_count + ONE;
            end
            if ((r_state == S_IDLE) && i_start) begin
                r_job_len   <= i_cfg_len;
                r_acc_cnt   <= '0;
                r_out_count <= '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_arr_in   <= '0;
            r_tag      <= '0;
            r_out_data <= '0;
        end else begin
            r_arr_in <= w_hs ? i_in_data : '0;
            r_tag    <= {r_tag[LAT-2:0], w_hs};
            if (r_tag[LAT-2]) begin
                r_out_data <= w_aligned;
            end
        end
    end

    assign o_out_valid = r_tag[LAT-1] && !i_rst;
    assign o_out_data  = r_out_data;
    assign o_out_count = r_out_count;

    // Row k+1 sees its byte k*PE_LAT cycles later so it meets the partial sum from above.
    for (genvar k = 0; k < 5; k++) begin : g_skew
        localparam int D = k * PE_LAT;
        if (D == 0) begin : g_direct
            assign w_lanes[8*k +: 8] = r_arr_in[8*k +: 8];
        end else begin : g_delay
            logic [7:0] r_dly [0:D-1];
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < D; i++) begin
                        r_dly[i] <= '0;
                    end
                end else begin
                    r_dly[0] <= r_arr_in[8*k +: 8];
                    for (int i = 1; i < D; i++) begin
                        r_dly[i] <= r_dly[i-1];
                    end
                end
            end
            assign w_lanes[8*k +: 8] = r_dly[D-1];
        end
    end

    // Column 1 finishes earliest, so it waits longest to line up with column 5.
    for (genvar c = 0; c < 5; c++) begin : g_deskew
        localparam int D = (4 - c) * PE_LAT;
        if (D == 0) begin : g_direct
            assign w_aligned[16*c +: 16] = i_arr_result[16*c +: 16];
        end else begin : g_delay
            logic [15:0] r_dly [0:D-1];
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < D; i++) begin
                        r_dly[i] <= '0;
                    end
                end else begin
                    r_dly[0] <= i_arr_result[16*c +: 16];
                    for (int i = 1; i < D; i++) begin
                        r_dly[i] <= r_dly[i-1];
                    end
                end
            end
            assign w_aligned[16*c +: 16] = r_dly[D-1];
        end
    end

endmodule
